// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder evaluation per clock, LSB first,
// with valid/ready handshakes on the operand and result sides and ALU-style flags.
module serial_add_sequencer #(
    parameter int unsigned WIDTH     = 64,
    parameter real         gateDelay = 0.05
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MsbCnt  = CW'(WIDTH - 2);

    // The cell delay only matters to gate-level models; here it is just sanity-checked.
    if (WIDTH < 2 || gateDelay < 0.0) begin : g_param_check
        $error("serial_add_sequencer: WIDTH must be >= 2 and gateDelay non-negative");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_count;
    logic             r_carry;
    logic             r_c_msb_in;
    logic             r_carry_out;
    logic             r_overflow;
    logic             w_accept;
    logic             w_s;
    logic             w_c;

    assign w_accept = start_valid && (r_state == StIdle);

    // Single full-adder cell shared across all bit positions.
    assign w_s = r_sh_a[0] ^ r_sh_b[0] ^ r_carry;
    assign w_c = (r_sh_a[0] & r_sh_b[0]) | (r_carry & (r_sh_a[0] ^ r_sh_b[0]));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: if (w_accept) w_state_next = StRun;
            StRun:  if (r_count == LastCnt) w_state_next = StDone;
            StDone: if (result_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_sum       <= '0;
            r_count     <= '0;
            r_carry     <= 1'b0;
            r_c_msb_in  <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
            r_sh_a      <= a;
            r_sh_b      <= b ^ {WIDTH{sub}};
            r_carry     <= sub;
            r_count     <= '0;
            r_sum       <= '0;
            r_c_msb_in  <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (r_state == StRun) begin
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_sh_a  <= r_sh_a >> 1;
            r_sh_b  <= r_sh_b >> 1;
            r_carry <= w_c;
            if (r_count == MsbCnt) begin
                r_c_msb_in <= w_c;
            end
            if (r_count == LastCnt) begin
                r_carry_out <= w_c;
                r_overflow  <= w_c ^ r_c_msb_in;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign start_ready  = (r_state == StIdle);
    assign result_valid = (r_state == StDone);
    assign busy         = (r_state != StIdle);
    assign sum          = r_sum;
    assign carry_out    = r_carry_out;
    assign overflow     = r_overflow;
    assign zero         = (r_state == StDone) && (r_sum == '0);
    assign negative     = (r_state == StDone) && r_sum[WIDTH-1];

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed self-checking bench for serial_add_sequencer at WIDTH=8.
module tb_serial_add_sequencer;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         result_valid;
    logic         result_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic         zero;
    logic         negative;
    logic         busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    serial_add_sequencer #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .sub         (sub),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .sum         (sum),
        .carry_out   (carry_out),
        .overflow    (overflow),
        .zero        (zero),
        .negative    (negative),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, carry_out, sum} computed as a whole-word operation.
    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic ms);
        logic [8:0] t;
        logic       ov;
        t  = {1'b0, ma} + {1'b0, (ms ? ~mb : mb)} + 9'(ms);
        ov = ms ? ((ma[7] != mb[7]) && (t[7] != ma[7]))
                : ((ma[7] == mb[7]) && (t[7] != ma[7]));
        return {ov, t[8], t[7:0]};
    endfunction

    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                         input logic ts, input logic [7:0] es, input logic ec,
                         input logic eo, input logic ez, input logic en, input int hold);
        int edges;
        bit got;
        @(negedge clk);
        check({tag, "_start_ready"}, 32'(start_ready), 32'd1);
        a            = ta;
        b            = tb;
        sub          = ts;
        start_valid  = 1'b1;
        result_ready = 1'b0;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        // Scramble operands during RUN; they must be ignored.
        a   = 8'($urandom);
        b   = 8'($urandom);
        sub = 1'($urandom);
        check({tag, "_busy_run"}, 32'(busy), 32'd1);
        check({tag, "_zero_run"}, 32'(zero), 32'd0);
        check({tag, "_rv_run"}, 32'(result_valid), 32'd0);
        edges = 0;
        got   = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (result_valid) got = 1;
        end
        check({tag, "_latency"}, 32'(edges), 32'd8);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_carry"}, 32'(carry_out), 32'(ec));
        check({tag, "_ovf"}, 32'(overflow), 32'(eo));
        check({tag, "_zero"}, 32'(zero), 32'(ez));
        check({tag, "_neg"}, 32'(negative), 32'(en));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_sum"}, 32'(sum), 32'(es));
            check({tag, "_hold_flags"}, 32'({carry_out, overflow, zero, negative}),
                  32'({ec, eo, ez, en}));
            check({tag, "_hold_state"}, 32'({result_valid, start_ready, busy}), 32'b101);
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        check({tag, "_idle"}, 32'({result_valid, start_ready, busy}), 32'b010);
    endtask

    initial begin
        logic [7:0] ta;
        logic [7:0] tb;
        logic       ts;
        logic [9:0] exp;
        int         edges;
        bit         got;
        bit         seen;

        reset_n      = 1'b1;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        a            = '0;
        b            = '0;
        sub          = 1'b0;
        #3 reset_n = 1'b0;
        #4;
        check("rst_outputs", 32'({sum, carry_out, overflow, zero, negative, result_valid, busy}),
              32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_start_ready", 32'(start_ready), 32'd1);

        do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        do_op("sub_05_05", 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        do_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        do_op("hold_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0, 5);

        // Reset in the middle of an operation.
        @(negedge clk);
        a           = 8'hFF;
        b           = 8'hFF;
        sub         = 1'b0;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_outputs",
              32'({sum, carry_out, overflow, zero, negative, result_valid, busy}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("midrst_start_ready", 32'(start_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (result_valid || busy) seen = 1;
        end
        check("midrst_no_stale", 32'(seen), 32'd0);

        // Back-to-back with start_valid and result_ready held high.
        @(posedge clk);
        #1;
        start_valid  = 1'b1;
        result_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ta  = 8'($urandom);
            tb  = 8'($urandom);
            ts  = 1'($urandom);
            exp = model(ta, tb, ts);
            check("b2b_idle", 32'(start_ready), 32'd1);
            a   = ta;
            b   = tb;
            sub = ts;
            @(posedge clk);
            #1;
            check("b2b_accept", 32'({busy, start_ready}), 32'b10);
            edges = 0;
            got   = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                a   = 8'($urandom);
                b   = 8'($urandom);
                sub = 1'($urandom);
                @(posedge clk);
                #1;
                edges++;
                if (result_valid) got = 1;
                else if (start_ready) check("b2b_ready_in_run", 32'(start_ready), 32'd0);
            end
            check("b2b_latency", 32'(edges), 32'd8);
            check("b2b_sum", 32'(sum), 32'(exp[7:0]));
            check("b2b_carry", 32'(carry_out), 32'(exp[8]));
            check("b2b_ovf", 32'(overflow), 32'(exp[9]));
            @(posedge clk);
            #1;
            check("b2b_no_accept_on_done", 32'({busy, start_ready}), 32'b01);
        end
        start_valid  = 1'b0;
        result_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
